turbo_intlv_addr_gen: RTL

//  Parametrised turbo interleaver address generator for the VHF OFDM turbo path.
//  A one-cycle id_enable pulse latches link_id, which selects a block size K and QPP coefficients (f1,f2).
//  The block then streams K addresses, natural or interleaved, under a valid/ready handshake:
//  pi(i) = (f1*i + f2*i^2) mod K, computed incrementally with adders only (no multipliers).
//  It sits between the link controller and the turbo encoder/decoder memory address port.

---
 rtl/turbo_intlv_addr_gen_pkg.sv | 55 +++++
 rtl/turbo_intlv_addr_gen_qpp_rom.sv | 23 ++
 rtl/turbo_intlv_addr_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/turbo_intlv_addr_gen_pkg.sv
// QPP interleaver shared types: table entry, coefficient table, FSM states, modular add.
// Pure declarations; no timing or flow control of its own.
package turbo_intlv_pkg;

  localparam int QPP_ADDR_W  = 13;
  localparam int QPP_ID_W    = 6;
  localparam int QPP_N_ENTRY = 16;

  typedef struct packed {
    logic [QPP_ADDR_W-1:0] k;
    logic [QPP_ADDR_W-1:0] f1;
    logic [QPP_ADDR_W-1:0] f2;
  } qpp_entry_t;

  // Every f1/f2 here is below its K, which keeps all mod_add operands in range.
  localparam qpp_entry_t QPP_TABLE [QPP_N_ENTRY] = '{
    '{13'd40,  13'd3,   13'd10 },
    '{13'd48,  13'd7,   13'd12 },
    '{13'd56,  13'd19,  13'd42 },
    '{13'd64,  13'd7,   13'd16 },
    '{13'd72,  13'd7,   13'd18 },
    '{13'd80,  13'd11,  13'd20 },
    '{13'd88,  13'd5,   13'd22 },
    '{13'd96,  13'd11,  13'd24 },
    '{13'd104, 13'd7,   13'd26 },
    '{13'd112, 13'd41,  13'd84 },
    '{13'd120, 13'd103, 13'd90 },
    '{13'd128, 13'd15,  13'd32 },
    '{13'd136, 13'd9,   13'd34 },
    '{13'd144, 13'd17,  13'd108},
    '{13'd152, 13'd9,   13'd38 },
    '{13'd160, 13'd21,  13'd120}
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [QPP_ADDR_W-1:0] mod_add(
    input logic [QPP_ADDR_W-1:0] a,
    input logic [QPP_ADDR_W-1:0] b,
    input logic [QPP_ADDR_W-1:0] k
  );
    logic [QPP_ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) begin
      sum = sum - {1'b0, k};
    end
    return sum[QPP_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/turbo_intlv_addr_gen_qpp_rom.sv
// QPP coefficient lookup: link_id -> {K, f1, f2}; combinational, zero for out-of-range ids.
// No handshake; the caller registers the result.
module qpp_rom
  import turbo_intlv_pkg::*;
#(
  parameter int ID_W    = QPP_ID_W,
  parameter int N_ENTRY = QPP_N_ENTRY
) (
  input  logic [ID_W-1:0] link_id,
  output qpp_entry_t      entry
);

  localparam int              IDX_W   = $clog2(N_ENTRY);
  localparam logic [ID_W-1:0] ID_LIMIT = ID_W'(N_ENTRY);

  always_comb begin
    entry = '0;
    if (link_id < ID_LIMIT) begin
      entry = QPP_TABLE[link_id[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/turbo_intlv_addr_gen.sv
// QPP turbo interleaver address stream: id_enable -> LOAD (1 cycle) -> K addresses, 1/cycle.
// valid/ready output; a stall freezes addr, last and all incremental state.
module turbo_intlv_addr_gen
  import turbo_intlv_pkg::*;
#(
  parameter int ADDR_W  = QPP_ADDR_W,
  parameter int ID_W    = QPP_ID_W,
  parameter int N_ENTRY = QPP_N_ENTRY
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              id_enable,
  input  logic [ID_W-1:0]   link_id,
  input  logic              mode,
  input  logic              out_ready,
  output logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              last,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [ID_W-1:0] ID_LIMIT = ID_W'(N_ENTRY);

  state_t                  state_q;
  state_t                  state_nxt;
  logic                    cfg_err_q;
  logic                    cfg_err_nxt;
  logic                    id_load;
  logic                    accept;
  logic [ID_W-1:0]         id_q;
  logic                    mode_q;
  logic [QPP_ADDR_W-1:0]   k_q;
  logic [QPP_ADDR_W-1:0]   km1_q;
  logic [QPP_ADDR_W-1:0]   i_q;
  logic [QPP_ADDR_W-1:0]   pi_q;
  logic [QPP_ADDR_W-1:0]   g_q;
  logic [QPP_ADDR_W-1:0]   d_q;
  qpp_entry_t              rom_entry;

  qpp_rom #(
    .ID_W    (ID_W),
    .N_ENTRY (N_ENTRY)
  ) u_qpp_rom (
    .link_id (id_q),
    .entry   (rom_entry)
  );

  assign accept = (state_q == ST_RUN) && out_ready;

  always_comb begin
    state_nxt   = state_q;
    cfg_err_nxt = 1'b0;
    id_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id_enable) begin
          if (link_id < ID_LIMIT) begin
            state_nxt = ST_LOAD;
            id_load   = 1'b1;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN: begin
        if (accept && (i_q == km1_q)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cfg_err_q <= cfg_err_nxt;
    end
  end

  // pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2, with g(0) = f1 + f2 (all mod K).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      id_q   <= '0;
      mode_q <= 1'b0;
      k_q    <= '0;
      km1_q  <= '0;
      i_q    <= '0;
      pi_q   <= '0;
      g_q    <= '0;
      d_q    <= '0;
    end else begin
      if (id_load) begin
        id_q   <= link_id;
        mode_q <= mode;
      end
      if (state_q == ST_LOAD) begin
        k_q   <= rom_entry.k;
        km1_q <= rom_entry.k - QPP_ADDR_W'(1);
        i_q   <= '0;
        pi_q  <= '0;
        g_q   <= mod_add(rom_entry.f1, rom_entry.f2, rom_entry.k);
        d_q   <= mod_add(rom_entry.f2, rom_entry.f2, rom_entry.k);
      end else if (accept) begin
        i_q  <= i_q + QPP_ADDR_W'(1);
        pi_q <= mod_add(pi_q, g_q, k_q);
        g_q  <= mod_add(g_q, d_q, k_q);
      end
    end
  end

  assign enable     = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign addr_valid = (state_q == ST_RUN);
  assign addr       = addr_valid ? (mode_q ? pi_q : i_q) : '0;
  assign last       = addr_valid && (i_q == km1_q);
  assign done       = (state_q == ST_DONE);
  assign cfg_err    = cfg_err_q;

endmodule
